// File: rtl/rob_multi_commit_pkg.sv
`default_nettype none
// rob_multi_commit_pkg: shared ROB types, defaults and helpers.
// Rev 1.0 - initial multi-commit release.
package rob_multi_commit_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [3:0]  xcpt_code_t;

  localparam int ROB_SIZE         = 16;
  localparam int ROB_COMMIT_WIDTH = 2;
  localparam int ROB_NUM_WB       = 2;
  localparam int ROB_IDX_BITS     = $clog2(ROB_SIZE);

  // rob_idx_t is sized from ROB_SIZE, so DEPTH must not exceed ROB_SIZE.
  typedef logic [ROB_IDX_BITS-1:0] rob_idx_t;

  localparam xcpt_code_t XCPT_NONE          = 4'd0;
  localparam xcpt_code_t XCPT_ILLEGAL_INSTR = 4'd2;
  localparam bus32_t     ADDR_XCPT          = 32'h0000_2000;

  typedef struct packed {
    logic       valid;
    logic       completed;
    bus32_t     pc;
    bus32_t     instr;
    logic [4:0] addr_rd;
    logic       write_enable;
    logic       store_to_mem;
    bus32_t     result;
    bus32_t     new_pc;
    logic       branch_taken;
    logic [15:0] kanata_id;
    logic       xcpt;
    xcpt_code_t xcpt_code;
  } rob_entry_t;

  typedef struct packed {
    logic       valid;
    rob_idx_t   idx;
    bus32_t     result;
    bus32_t     new_pc;
    logic       branch_taken;
    logic       xcpt;
    xcpt_code_t xcpt_code;
  } rob_wb_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_multi_commit_if.sv
`default_nettype none
// rob_multi_commit_if: dispatch, writeback and commit bundle of the ROB.
// Rev 1.0 - initial multi-commit release.
interface rob_multi_commit_if #(
  parameter int DEPTH        = rob_multi_commit_pkg::ROB_SIZE,
  parameter int COMMIT_WIDTH = rob_multi_commit_pkg::ROB_COMMIT_WIDTH,
  parameter int NUM_WB       = rob_multi_commit_pkg::ROB_NUM_WB,
  parameter int IDX_BITS     = $clog2(DEPTH)
);
  import rob_multi_commit_pkg::*;

  logic                              alloc_valid_i;
  rob_entry_t                        alloc_entry_i;
  logic                              alloc_ready_o;
  logic [IDX_BITS-1:0]               alloc_idx_o;
  rob_wb_t    [NUM_WB-1:0]           wb_i;
  logic       [COMMIT_WIDTH-1:0]     commit_valid_o;
  rob_entry_t [COMMIT_WIDTH-1:0]     commit_entry_o;
  logic                              flush_o;
  bus32_t                            flush_pc_o;
  logic [IDX_BITS:0]                 count_o;

  modport master (
    output alloc_valid_i, alloc_entry_i, wb_i,
    input  alloc_ready_o, alloc_idx_o, commit_valid_o, commit_entry_o,
           flush_o, flush_pc_o, count_o
  );

  modport slave (
    input  alloc_valid_i, alloc_entry_i, wb_i,
    output alloc_ready_o, alloc_idx_o, commit_valid_o, commit_entry_o,
           flush_o, flush_pc_o, count_o
  );

endinterface
`default_nettype wire

// File: rtl/rob_commit_select.sv
`default_nettype none
// rob_commit_select: picks the in-order retire mask from the head window
// and derives the flush request. Rev 1.0 - initial release.
module rob_commit_select
  import rob_multi_commit_pkg::*;
#(
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH
) (
  input  rob_entry_t [COMMIT_WIDTH-1:0] window,
  output logic       [COMMIT_WIDTH-1:0] commit_mask,
  output logic                          flush,
  output bus32_t                        flush_pc
);

  logic blocked;

  // A slot retires only if all older slots retire and none of them redirects.
  always_comb begin
    commit_mask = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    blocked     = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (!blocked && window[k].valid && window[k].completed) begin
        commit_mask[k] = 1'b1;
        if (window[k].xcpt || window[k].branch_taken) begin
          flush    = 1'b1;
          flush_pc = window[k].xcpt ? ADDR_XCPT : window[k].new_pc;
          blocked  = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_multi_commit.sv
`default_nettype none
// rob_multi_commit: DEPTH-entry reorder buffer, NUM_WB writeback ports,
// COMMIT_WIDTH in-order retire. ROB_PERF_EN adds perf counters. Rev 1.0.
module rob_multi_commit
  import rob_multi_commit_pkg::*;
#(
  parameter int DEPTH        = ROB_SIZE,
  parameter int COMMIT_WIDTH = ROB_COMMIT_WIDTH,
  parameter int NUM_WB       = ROB_NUM_WB,
  parameter int IDX_BITS     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  rob_multi_commit_if.slave rob
`ifdef ROB_PERF_EN
  ,
  output logic [31:0]       perf_commits_o,
  output logic [31:0]       perf_flushes_o,
  output logic [31:0]       perf_full_cycles_o
`endif
);

  logic [IDX_BITS:0]             head, tail, head_next, count;
  logic [DEPTH-1:0]              valid_q;
  rob_entry_t                    mem [DEPTH];
  rob_entry_t [COMMIT_WIDTH-1:0] window;
  logic [COMMIT_WIDTH-1:0]       commit_mask;
  logic                          flush;
  bus32_t                        flush_pc;
  logic                          full, alloc_ready, alloc_fire;
  logic [2:0]                    n_commit;

  assign count       = tail - head;
  assign full        = (tail[IDX_BITS-1:0] == head[IDX_BITS-1:0]) &&
                       (tail[IDX_BITS] != head[IDX_BITS]);
  assign alloc_ready = !full && !flush;
  assign alloc_fire  = rob.alloc_valid_i && alloc_ready;
  assign n_commit    = popcount4(4'(commit_mask));
  assign head_next   = head + (IDX_BITS+1)'(n_commit);

  always_comb begin
    logic [IDX_BITS-1:0] slot;
    window = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot            = head[IDX_BITS-1:0] + IDX_BITS'(k);
      window[k]       = mem[slot];
      window[k].valid = valid_q[slot] && ((IDX_BITS+1)'(k) < count);
    end
  end

  rob_commit_select #(.COMMIT_WIDTH(COMMIT_WIDTH)) u_select (
    .window      (window),
    .commit_mask (commit_mask),
    .flush       (flush),
    .flush_pc    (flush_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
      head    <= head_next;
      tail    <= head_next;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_mask[k]) valid_q[head[IDX_BITS-1:0] + IDX_BITS'(k)] <= 1'b0;
      end
      if (alloc_fire) begin
        valid_q[tail[IDX_BITS-1:0]] <= 1'b1;
        tail                        <= tail + 1'b1;
      end
      head <= head_next;
    end
  end

  // Payload needs no reset: every read is qualified by valid_q.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if (alloc_fire) begin
        mem[tail[IDX_BITS-1:0]]           <= rob.alloc_entry_i;
        mem[tail[IDX_BITS-1:0]].valid     <= 1'b1;
        mem[tail[IDX_BITS-1:0]].completed <= rob.alloc_entry_i.xcpt;
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (rob.wb_i[p].valid && valid_q[rob.wb_i[p].idx[IDX_BITS-1:0]]) begin
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].completed    <= 1'b1;
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].result       <= rob.wb_i[p].result;
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].new_pc       <= rob.wb_i[p].new_pc;
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].branch_taken <= rob.wb_i[p].branch_taken;
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].xcpt         <= rob.wb_i[p].xcpt;
          mem[rob.wb_i[p].idx[IDX_BITS-1:0]].xcpt_code    <= rob.wb_i[p].xcpt_code;
        end
      end
    end
  end

  assign rob.alloc_ready_o  = alloc_ready;
  assign rob.alloc_idx_o    = tail[IDX_BITS-1:0];
  assign rob.commit_valid_o = commit_mask;
  assign rob.commit_entry_o = window;
  assign rob.flush_o        = flush;
  assign rob.flush_pc_o     = flush_pc;
  assign rob.count_o        = count;

`ifdef ROB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_commits_o     <= '0;
      perf_flushes_o     <= '0;
      perf_full_cycles_o <= '0;
    end else begin
      perf_commits_o     <= perf_commits_o + 32'(n_commit);
      perf_flushes_o     <= perf_flushes_o + 32'(flush);
      perf_full_cycles_o <= perf_full_cycles_o + 32'(full);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
`default_nettype none
// tb_rob_multi_commit: scoreboard bench for rob_multi_commit (DEPTH=16).
// Rev 1.0 - initial release.
module tb_rob_multi_commit;
  import rob_multi_commit_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = 2;
  localparam int NWB   = 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   exp_tail;
  logic [31:0] sb[$];

  rob_multi_commit_if #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW), .NUM_WB(NWB)) rif ();

`ifdef ROB_PERF_EN
  logic [31:0] perf_commits, perf_flushes, perf_full;
`endif

  rob_multi_commit #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW), .NUM_WB(NWB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (rif)
`ifdef ROB_PERF_EN
    ,
    .perf_commits_o     (perf_commits),
    .perf_flushes_o     (perf_flushes),
    .perf_full_cycles_o (perf_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic rob_entry_t mk_entry(input logic [31:0] pc, input logic xc, input xcpt_code_t code);
    rob_entry_t e;
    e           = '0;
    e.pc        = pc;
    e.instr     = pc ^ 32'h0000_0013;
    e.addr_rd   = pc[6:2];
    e.write_enable = 1'b1;
    e.kanata_id = pc[15:0];
    e.xcpt      = xc;
    e.xcpt_code = code;
    return e;
  endfunction

  function automatic rob_wb_t mk_wb(input int idx, input logic br, input logic [31:0] npc);
    rob_wb_t w;
    w              = '0;
    w.valid        = 1'b1;
    w.idx          = rob_idx_t'(idx & (DEPTH - 1));
    w.result       = 32'hC0DE_0000 + 32'(idx);
    w.new_pc       = npc;
    w.branch_taken = br;
    return w;
  endfunction

  task automatic alloc(input logic [31:0] pc);
    rif.alloc_valid_i = 1'b1;
    rif.alloc_entry_i = mk_entry(pc, 1'b0, XCPT_NONE);
  endtask

  // Called at the drive point; returns at the next drive point once empty.
  task automatic wait_empty(input string tag);
    int c;
    c = 0;
    @(negedge clk);
    while (rif.count_o != 0 && c < 50) begin
      step();
      @(negedge clk);
      c++;
    end
    check(tag, 64'(rif.count_o), 64'd0);
    step();
  endtask

  // Scoreboard: accepted allocations in, retired pcs out in order.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      for (int k = 0; k < CW; k++) begin
        if (rif.commit_valid_o[k]) begin
          if (sb.size() == 0) begin
            check("commit_unexpected", 64'(rif.commit_entry_o[k].pc), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check("commit_pc_order", 64'(rif.commit_entry_o[k].pc), 64'(e));
          end
        end
      end
      if (rif.flush_o) sb.delete();
      if (rif.alloc_valid_i && rif.alloc_ready_o) sb.push_back(rif.alloc_entry_i.pc);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_tail = 0;
    rst_n    = 1'b0;
    rif.alloc_valid_i = 1'b0;
    rif.alloc_entry_i = '0;
    rif.wb_i          = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_count",  64'(rif.count_o), 64'd0);
    check("rst_ready",  64'(rif.alloc_ready_o), 64'd1);
    check("rst_idx",    64'(rif.alloc_idx_o), 64'd0);
    check("rst_commit", 64'(rif.commit_valid_o), 64'd0);
    check("rst_flush",  64'(rif.flush_o), 64'd0);
    check("rst_fpc",    64'(rif.flush_pc_o), 64'd0);
    step();

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      alloc(32'h1000 + 32'(4 * i));
      @(negedge clk);
      check("fill_idx",   64'(rif.alloc_idx_o), 64'(exp_tail & (DEPTH - 1)));
      check("fill_ready", 64'(rif.alloc_ready_o), 64'd1);
      step();
      exp_tail++;
    end
    alloc(32'hDEAD_0000);
    @(negedge clk);
    check("full_ready", 64'(rif.alloc_ready_o), 64'd0);
    check("full_count", 64'(rif.count_o), 64'd16);
    step();
    rif.alloc_valid_i = 1'b0;
    for (int i = 0; i < DEPTH / 2; i++) begin
      rif.wb_i[0] = mk_wb(exp_tail - DEPTH + 2 * i, 1'b0, 32'h0);
      rif.wb_i[1] = mk_wb(exp_tail - DEPTH + 2 * i + 1, 1'b0, 32'h0);
      step();
    end
    rif.wb_i = '0;
    wait_empty("drain_fill");

    // Out-of-order writeback 3,1,0,2
    for (int i = 0; i < 4; i++) begin
      alloc(32'h3000 + 32'(4 * i));
      step();
      exp_tail++;
    end
    rif.alloc_valid_i = 1'b0;
    rif.wb_i[0] = mk_wb(exp_tail - 1, 1'b0, 32'h0);
    step();
    rif.wb_i[0] = mk_wb(exp_tail - 3, 1'b0, 32'h0);
    @(negedge clk);
    check("ooo_hold", 64'(rif.commit_valid_o), 64'd0);
    step();
    rif.wb_i[0] = mk_wb(exp_tail - 4, 1'b0, 32'h0);
    @(negedge clk);
    check("ooo_hold2", 64'(rif.commit_valid_o), 64'd0);
    step();
    rif.wb_i[0] = mk_wb(exp_tail - 2, 1'b0, 32'h0);
    @(negedge clk);
    check("ooo_c01",    64'(rif.commit_valid_o), 64'd3);
    check("ooo_c01_pc", 64'(rif.commit_entry_o[0].pc), 64'h3000);
    step();
    rif.wb_i = '0;
    @(negedge clk);
    check("ooo_c23",    64'(rif.commit_valid_o), 64'd3);
    check("ooo_c23_pc", 64'(rif.commit_entry_o[1].pc), 64'h300C);
    step();
    @(negedge clk);
    check("ooo_empty", 64'(rif.count_o), 64'd0);
    step();

    // Taken branch in slot 1
    for (int i = 0; i < 3; i++) begin
      alloc(32'h4000 + 32'(4 * i));
      step();
      exp_tail++;
    end
    rif.alloc_valid_i = 1'b0;
    rif.wb_i[0] = mk_wb(exp_tail - 1, 1'b0, 32'h0);
    step();
    rif.wb_i[0] = mk_wb(exp_tail - 3, 1'b0, 32'h0);
    rif.wb_i[1] = mk_wb(exp_tail - 2, 1'b1, 32'h0000_0100);
    alloc(32'h5000);
    step();
    rif.wb_i = '0;
    @(negedge clk);
    check("br_commit", 64'(rif.commit_valid_o), 64'd3);
    check("br_flush",  64'(rif.flush_o), 64'd1);
    check("br_fpc",    64'(rif.flush_pc_o), 64'h100);
    check("br_ready",  64'(rif.alloc_ready_o), 64'd0);
    step();
    rif.alloc_valid_i = 1'b0;
    exp_tail--;
    @(negedge clk);
    check("br_count", 64'(rif.count_o), 64'd0);
    check("br_flush_off", 64'(rif.flush_o), 64'd0);
    check("br_tail", 64'(rif.alloc_idx_o), 64'(exp_tail & (DEPTH - 1)));
    step();

    // Decode exception retires without writeback
    rif.alloc_valid_i = 1'b1;
    rif.alloc_entry_i = mk_entry(32'h6000, 1'b1, XCPT_ILLEGAL_INSTR);
    step();
    exp_tail++;
    rif.alloc_valid_i = 1'b0;
    @(negedge clk);
    check("xc_commit", 64'(rif.commit_valid_o), 64'd1);
    check("xc_flush",  64'(rif.flush_o), 64'd1);
    check("xc_fpc",    64'(rif.flush_pc_o), 64'h2000);
    check("xc_bit",    64'(rif.commit_entry_o[0].xcpt), 64'd1);
    check("xc_code",   64'(rif.commit_entry_o[0].xcpt_code), 64'(XCPT_ILLEGAL_INSTR));
    step();
    @(negedge clk);
    check("xc_count", 64'(rif.count_o), 64'd0);
    step();

    // Steady-state wrap
    for (int i = 0; i < 40; i++) begin
      alloc(32'h8000 + 32'(4 * i));
      if (i > 0) rif.wb_i[0] = mk_wb(exp_tail - 1, 1'b0, 32'h0);
      @(negedge clk);
      check("wrap_ready", 64'(rif.alloc_ready_o), 64'd1);
      step();
      exp_tail++;
    end
    rif.alloc_valid_i = 1'b0;
    rif.wb_i[0] = mk_wb(exp_tail - 1, 1'b0, 32'h0);
    step();
    rif.wb_i = '0;
    wait_empty("drain_wrap");

    // Full from a wrapped offset; commit while full does not free a slot
    for (int i = 0; i < DEPTH; i++) begin
      alloc(32'h9000 + 32'(4 * i));
      step();
      exp_tail++;
    end
    alloc(32'h9100);
    rif.wb_i[0] = mk_wb(exp_tail - DEPTH, 1'b0, 32'h0);
    @(negedge clk);
    check("full2_ready", 64'(rif.alloc_ready_o), 64'd0);
    check("full2_count", 64'(rif.count_o), 64'd16);
    step();
    rif.wb_i = '0;
    @(negedge clk);
    check("full2_commit", 64'(rif.commit_valid_o), 64'd1);
    check("full2_noreuse", 64'(rif.alloc_ready_o), 64'd0);
    step();
    @(negedge clk);
    check("full2_free",  64'(rif.alloc_ready_o), 64'd1);
    check("full2_cnt15", 64'(rif.count_o), 64'd15);
    check("full2_idx",   64'(rif.alloc_idx_o), 64'(exp_tail & (DEPTH - 1)));
    step();
    exp_tail++;
    rif.alloc_valid_i = 1'b0;
    for (int i = 0; i < DEPTH / 2; i++) begin
      rif.wb_i[0] = mk_wb(exp_tail - DEPTH + 2 * i, 1'b0, 32'h0);
      rif.wb_i[1] = mk_wb(exp_tail - DEPTH + 2 * i + 1, 1'b0, 32'h0);
      step();
    end
    rif.wb_i = '0;
    wait_empty("drain_full2");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) begin
      alloc(32'hA000 + 32'(4 * i));
      step();
      exp_tail++;
    end
    rif.alloc_valid_i = 1'b0;
    rif.wb_i[0] = mk_wb(exp_tail - 6, 1'b0, 32'h0);
    step();
    rif.wb_i = '0;
    @(negedge clk);
    check("pre_rst_count", 64'(rif.count_o), 64'd7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 64'(rif.count_o), 64'd0);
    check("arst_idx",   64'(rif.alloc_idx_o), 64'd0);
    check("arst_ready", 64'(rif.alloc_ready_o), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    exp_tail = 0;
    @(negedge clk);
    check("post_rst_count", 64'(rif.count_o), 64'd0);
    check("post_rst_idx",   64'(rif.alloc_idx_o), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
